// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit.
// Funct3 codes, result bundle and datapath width.
package branch_resolve_unit_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            taken;
    logic            mispredict;
    logic            illegal;
    logic [XLEN-1:0] redirect_pc;
  } br_result_t;

endpackage

// File: rtl/branch_resolve_unit_cmp.sv
// Branch comparator: equality plus signed/unsigned less-than.
// un selects the unsigned compare.
module branch_resolve_unit_cmp
  import branch_resolve_unit_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            un,
  output logic            eq,
  output logic            lt
);

  assign eq = (a == b);
  assign lt = un ? (a < b) : ($signed(a) < $signed(b));

endmodule

// File: rtl/branch_resolve_unit.sv
// Two-stage branch resolution: S1 compares, S2 holds the result.
// Mispredicts squash the younger op sitting in S1.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_taken,
  input  logic [XLEN-1:0] in_pred_target,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic            out_taken,
  output logic            out_mispredict,
  output logic            out_illegal,
  output logic [XLEN-1:0] out_redirect_pc,
  output logic            upd_valid,
  output logic [XLEN-1:0] upd_pc,
  output logic            upd_taken,
  output logic [XLEN-1:0] br_count,
  output logic [XLEN-1:0] mis_count
);

  logic            s1_valid;
  logic [2:0]      s1_funct3;
  logic [XLEN-1:0] s1_rs1;
  logic [XLEN-1:0] s1_rs2;
  logic [XLEN-1:0] s1_pc;
  logic [XLEN-1:0] s1_imm;
  logic            s1_pred_taken;
  logic [XLEN-1:0] s1_pred_target;

  logic            s2_valid;
  br_result_t      s2_res;

  logic            br_eq;
  logic            br_lt;
  logic            taken;
  logic            illegal;
  logic [XLEN-1:0] target;
  br_result_t      s1_res;

  logic handoff;
  logic mis_handoff;
  logic s1_adv;
  logic accept;
  logic fire;

  branch_resolve_unit_cmp u_cmp (
    .a  (s1_rs1),
    .b  (s1_rs2),
    .un (s1_funct3[1]),
    .eq (br_eq),
    .lt (br_lt)
  );

  always_comb begin
    taken   = 1'b0;
    illegal = 1'b0;
    unique case (1'b1)
      s1_funct3 == F3_BEQ:  taken = br_eq;
      s1_funct3 == F3_BNE:  taken = !br_eq;
      s1_funct3 == F3_BLT:  taken = br_lt;
      s1_funct3 == F3_BGE:  taken = !br_lt;
      s1_funct3 == F3_BLTU: taken = br_lt;
      s1_funct3 == F3_BGEU: taken = !br_lt;
      default:              illegal = 1'b1;
    endcase
  end

  always_comb begin
    target             = s1_pc + s1_imm;
    s1_res.pc          = s1_pc;
    s1_res.taken       = taken;
    s1_res.illegal     = illegal;
    s1_res.mispredict  = !illegal &&
                         ((taken != s1_pred_taken) ||
                          (taken && s1_pred_target != target));
    s1_res.redirect_pc = taken ? target : s1_pc + XLEN'(4);
  end

  assign handoff     = s2_valid && out_ready;
  assign mis_handoff = handoff && s2_res.mispredict;
  assign s1_adv      = !s2_valid || handoff;
  assign in_ready    = !flush && (!s1_valid || s1_adv);
  assign accept      = in_valid && in_ready;
  // Reset and flush both cancel a handoff's side effects.
  assign fire        = rst_n && !flush && handoff &&
                       !s2_res.illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      br_count  <= '0;
      mis_count <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (s1_adv) s2_valid <= s1_valid && !mis_handoff;
      if (accept) s1_valid <= 1'b1;
      else if (s1_adv) s1_valid <= 1'b0;
      if (fire) br_count <= br_count + XLEN'(1);
      if (fire && s2_res.mispredict)
        mis_count <= mis_count + XLEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_funct3      <= in_funct3;
      s1_rs1         <= in_rs1;
      s1_rs2         <= in_rs2;
      s1_pc          <= in_pc;
      s1_imm         <= in_imm;
      s1_pred_taken  <= in_pred_taken;
      s1_pred_target <= in_pred_target;
    end
    if (s1_adv) s2_res <= s1_res;
  end

  assign out_valid       = s2_valid;
  assign out_pc          = s2_res.pc;
  assign out_taken       = s2_res.taken;
  assign out_mispredict  = s2_res.mispredict;
  assign out_illegal     = s2_res.illegal;
  assign out_redirect_pc = s2_res.redirect_pc;
  assign upd_valid       = fire;
  assign upd_pc          = s2_res.pc;
  assign upd_taken       = s2_res.taken;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Randomized and directed bench for branch_resolve_unit.
// Ops are tracked in an in-order queue and scored at handoff.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_funct3;
  logic [31:0] in_rs1, in_rs2, in_pc, in_imm;
  logic        in_pred_taken;
  logic [31:0] in_pred_target;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic        out_taken, out_mispredict, out_illegal;
  logic [31:0] out_redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] br_count, mis_count;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_pred_taken(in_pred_taken),
    .in_pred_target(in_pred_target),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_taken(out_taken),
    .out_mispredict(out_mispredict),
    .out_illegal(out_illegal),
    .out_redirect_pc(out_redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken),
    .br_count(br_count), .mis_count(mis_count)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, imm, ptgt;
    logic        pt;
  } op_t;

  typedef struct packed {
    logic        tk, mis, ill;
    logic [31:0] redir;
  } exp_t;

  int errors = 0, checks = 0;
  op_t q[$];
  logic [31:0] m_br = 0, m_mis = 0;
  int cyc = 0, h_cyc = 0, hcount = 0, upd_n = 0;
  int start_cyc, h0, u0;
  logic h_tk, h_mis, h_ill, last_acc;
  logic [31:0] h_redir, snap_br, snap_mis;
  logic p_stall = 1'b0, p_tk, p_mis, p_ill;
  logic [31:0] p_pc, p_redir;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(op_t o);
    exp_t e;
    logic [31:0] tgt;
    tgt   = o.pc + o.imm;
    e.ill = 1'b0;
    e.tk  = 1'b0;
    case (o.f3)
      3'd0: e.tk = (o.rs1 == o.rs2);
      3'd1: e.tk = (o.rs1 != o.rs2);
      3'd4: e.tk = ($signed(o.rs1) < $signed(o.rs2));
      3'd5: e.tk = ($signed(o.rs1) >= $signed(o.rs2));
      3'd6: e.tk = (o.rs1 < o.rs2);
      3'd7: e.tk = (o.rs1 >= o.rs2);
      default: e.ill = 1'b1;
    endcase
    e.mis = !e.ill && ((e.tk != o.pt) ||
                       (e.tk && o.ptgt != tgt));
    e.redir = e.tk ? tgt : o.pc + 32'd4;
    return e;
  endfunction

  task automatic step();
    op_t  o, cur;
    exp_t e;
    logic hs, exp_upd;
    #1;
    check("br_count", br_count, m_br);
    check("mis_count", mis_count, m_mis);
    if (p_stall) begin
      check("hold_valid", out_valid, 1);
      check("hold_pc", out_pc, p_pc);
      check("hold_flags", {out_taken, out_mispredict, out_illegal},
            {p_tk, p_mis, p_ill});
      check("hold_redir", out_redirect_pc, p_redir);
    end
    hs = out_valid && out_ready;
    check("in_ready", in_ready,
          !flush && (q.size() < 2 || hs));
    if (out_valid && q.size() == 0)
      check("spurious_out", out_valid, 0);
    exp_upd = 1'b0;
    if (hs && q.size() > 0) begin
      o = q[0];
      e = model(o);
      exp_upd = !flush && !e.ill;
      check("out_pc", out_pc, o.pc);
      check("out_taken", out_taken, e.tk);
      check("out_illegal", out_illegal, e.ill);
      check("out_mispredict", out_mispredict, e.mis);
      if (e.mis) check("out_redirect", out_redirect_pc, e.redir);
    end
    check("upd_valid", upd_valid, exp_upd);
    if (exp_upd) begin
      check("upd_pc", upd_pc, o.pc);
      check("upd_taken", upd_taken, e.tk);
    end
    if (upd_valid) upd_n++;
    if (hs && q.size() > 0 && !flush) begin
      void'(q.pop_front());
      if (!e.ill) m_br++;
      if (e.mis) m_mis++;
      hcount++;
      h_cyc = cyc; h_tk = e.tk; h_mis = e.mis;
      h_ill = e.ill; h_redir = e.redir;
      if (e.mis) q.delete();
    end
    last_acc = in_valid && in_ready && !flush;
    if (flush) q.delete();
    else if (in_valid && in_ready) begin
      cur.f3 = in_funct3; cur.rs1 = in_rs1; cur.rs2 = in_rs2;
      cur.pc = in_pc; cur.imm = in_imm;
      cur.pt = in_pred_taken; cur.ptgt = in_pred_target;
      q.push_back(cur);
    end
    p_stall = out_valid && !out_ready && !flush;
    p_pc = out_pc; p_tk = out_taken; p_mis = out_mispredict;
    p_ill = out_illegal; p_redir = out_redirect_pc;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                       logic [31:0] pc, logic [31:0] imm,
                       logic pt, logic [31:0] ptgt);
    in_funct3 = f3; in_rs1 = a; in_rs2 = b; in_pc = pc;
    in_imm = imm; in_pred_taken = pt; in_pred_target = ptgt;
  endtask

  task automatic drive_rand(logic good);
    op_t  o;
    exp_t e;
    o.f3 = 3'($urandom_range(0, 7));
    case ($urandom_range(0, 3))
      0: begin o.rs1 = $urandom_range(0, 3);
               o.rs2 = $urandom_range(0, 3); end
      1: begin o.rs1 = 32'hFFFF_FFFF - $urandom_range(0, 2);
               o.rs2 = $urandom_range(0, 2); end
      2: begin o.rs1 = $urandom; o.rs2 = o.rs1; end
      default: begin o.rs1 = $urandom; o.rs2 = $urandom; end
    endcase
    o.pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    o.imm = {{19{$urandom_range(0, 1) == 1}},
             12'($urandom_range(0, 4095)), 1'b0};
    o.pt  = $urandom_range(0, 1) == 1;
    o.ptgt = ($urandom_range(0, 1) == 1) ? o.pc + o.imm : $urandom;
    if (good) begin
      e = model(o);
      if (e.ill) o.f3 = 3'd0;
      e = model(o);
      o.pt = e.tk; o.ptgt = o.pc + o.imm;
    end
    drive(o.f3, o.rs1, o.rs2, o.pc, o.imm, o.pt, o.ptgt);
  endtask

  task automatic send(logic [2:0] f3, logic [31:0] a, logic [31:0] b,
                      logic [31:0] pc, logic [31:0] imm,
                      logic pt, logic [31:0] ptgt);
    drive(f3, a, b, pc, imm, pt, ptgt);
    in_valid = 1; out_ready = 1; flush = 0;
    start_cyc = cyc; h0 = hcount; u0 = upd_n;
    step();
    in_valid = 0;
    for (int i = 0; i < 6 && hcount == h0; i++) step();
    check("latency", h_cyc - start_cyc, 2);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 1; flush = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_upd_valid", upd_valid, 0);
    check("rst_br_count", br_count, 0);
    check("rst_mis_count", mis_count, 0);
    @(negedge clk);
    rst_n = 1;
    #1 check("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // BLT signed: -1 < 1, predicted not-taken
    send(3'd4, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h40, 0, 0);
    check("blt_taken", h_tk, 1);
    check("blt_mis", h_mis, 1);
    check("blt_redir", h_redir, 32'h140);
    step();
    check("blt_upd_pulses", upd_n - u0, 1);
    check("blt_mis_count", mis_count, 1);

    send(3'd6, 32'hFFFF_FFFF, 32'd1, 32'h200, 32'h40, 0, 0);
    check("bltu_taken", h_tk, 0);
    check("bltu_mis", h_mis, 0);
    step();
    check("bltu_br_count", br_count, 2);
    check("bltu_mis_count", mis_count, 1);

    send(3'd0, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'd8, 1, 32'd4);
    check("beq_wrap_taken", h_tk, 1);
    check("beq_wrap_mis", h_mis, 0);
    send(3'd0, 32'd5, 32'd5, 32'hFFFF_FFFC, 32'd8, 0, 32'd0);
    check("beq_wrap_redir", h_redir, 32'h0000_0004);

    step();
    snap_br = br_count; snap_mis = mis_count;
    send(3'd2, 32'd1, 32'd1, 32'h300, 32'h10, 1, 32'h310);
    check("illegal_flag", h_ill, 1);
    check("illegal_taken", h_tk, 0);
    check("illegal_mis", h_mis, 0);
    check("illegal_upd", upd_n - u0, 0);
    step();
    check("illegal_br_count", br_count, snap_br);
    check("illegal_mis_count", mis_count, snap_mis);

    // three back-to-back ops into a stalled output
    h0 = hcount;
    begin
      int k;
      k = 0;
      drive_rand(1);
      for (int t = 0; t < 14; t++) begin
        out_ready = (t >= 5);
        in_valid  = (k < 3);
        step();
        if (last_acc) begin k++; drive_rand(1); end
      end
      in_valid = 0;
      check("b2b_accepted", k, 3);
    end
    check("b2b_released", hcount - h0, 3);

    // mispredict squashes the younger op in S1
    h0 = hcount; out_ready = 1;
    drive(3'd1, 32'd1, 32'd2, 32'h400, 32'h20, 0, 0);
    in_valid = 1; step();
    drive(3'd0, 32'd3, 32'd3, 32'h404, 32'h20, 1, 32'h424);
    step();
    in_valid = 0;
    repeat (4) step();
    check("squash_handoffs", hcount - h0, 1);

    // flush while S2 is stalled
    out_ready = 0;
    drive(3'd0, 32'd7, 32'd7, 32'h500, 32'h8, 1, 32'h508);
    in_valid = 1; step();
    in_valid = 0; step();
    #1 check("stall_out_valid", out_valid, 1);
    snap_br = br_count; snap_mis = mis_count;
    step();
    flush = 1; step();
    flush = 0;
    #1 check("flush_out_valid", out_valid, 0);
    step();
    check("flush_br_count", br_count, snap_br);
    check("flush_mis_count", mis_count, snap_mis);

    for (int i = 0; i < 3000; i++) begin
      drive_rand($urandom_range(0, 3) == 0);
      in_valid  = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 9) < 7;
      flush     = $urandom_range(0, 49) == 0;
      step();
    end
    in_valid = 0; flush = 0; out_ready = 1;
    for (int i = 0; i < 20 && q.size() > 0; i++) step();
    check("drain_empty", q.size(), 0);

    // reset during a stalled handoff
    out_ready = 0;
    drive(3'd1, 32'd1, 32'd2, 32'h600, 32'h8, 1, 32'h608);
    in_valid = 1; step();
    in_valid = 0; step();
    #1 check("pre_rst_valid", out_valid, 1);
    @(negedge clk);
    rst_n = 0; out_ready = 1;
    #1 check("rst_hs_upd", upd_valid, 0);
    @(negedge clk);
    #1 check("rst_hs_valid", out_valid, 0);
    check("rst_hs_br", br_count, 0);
    check("rst_hs_mis", mis_count, 0);
    q.delete(); m_br = 0; m_mis = 0; p_stall = 0;
    @(negedge clk);
    rst_n = 1;
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
